// File: rtl/hanming_spi_rx.sv
// SPI mode-0 slave receiver for 12-bit Hamming codewords, MSB-first, streaming under one chip-select.
// Optional frame/error statistics counters are compiled in with `define HANMING_SPI_RX_STAT_EN.
module hanming_spi_rx #(
    parameter int FRAME_BITS  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EN,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic [FRAME_BITS-1:0] Data_in,
    output logic                  Data_Fram,
    output logic                  busy,
    output logic                  short_err,
`ifdef HANMING_SPI_RX_STAT_EN
    output logic [15:0]           good_cnt,
    output logic [15:0]           short_cnt,
`endif
    output logic                  dbg_state
);
    localparam int CW = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_hist, r_rise, r_cs_d, r_mosi_d, r_armed;
    logic                   w_sclk_s, w_cs_s, w_mosi_s;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_bit_cnt, w_cnt_nxt;
    logic [FRAME_BITS-1:0]  r_shreg, w_shreg_nxt, w_word, r_data_in;
    logic                   w_complete, w_short, w_last;
    logic                   r_fram_pend, r_data_fram, r_short_err;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // Rise flag is registered; cs and mosi get one matching stage so all three stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_rise      <= 1'b0;
            r_cs_d      <= 1'b1;
            r_mosi_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_hist <= w_sclk_s;
            r_rise      <= w_sclk_s & ~r_sclk_hist;
            r_cs_d      <= w_cs_s;
            r_mosi_d    <= w_mosi_s;
        end
    end

    // A frame may only start after cs_n has been seen high while enabled.
    always_ff @(posedge clk) begin
        if (rst || !EN) r_armed <= 1'b0;
        else if (r_cs_d) r_armed <= 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_complete  = 1'b0;
        w_short     = 1'b0;
        w_last      = 1'b0;
        w_word      = {r_shreg[FRAME_BITS-2:0], r_mosi_d};
        if (!EN) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shreg_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_cs_d && r_armed) begin
                        w_state_nxt = S_SHIFT;
                        w_cnt_nxt   = '0;
                        w_shreg_nxt = '0;
                        if (r_rise) begin
                            w_shreg_nxt = {{(FRAME_BITS-1){1'b0}}, r_mosi_d};
                            w_cnt_nxt   = CW'(1);
                        end
                    end
                end
                S_SHIFT: begin
                    w_last = r_rise && (r_bit_cnt == LAST_BIT);
                    if (r_rise) begin
                        w_shreg_nxt = w_word;
                        w_cnt_nxt   = w_last ? '0 : r_bit_cnt + CW'(1);
                        w_complete  = w_last;
                    end
                    // A final bit landing with the cs_n rise still completes the frame.
                    if (r_cs_d) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_shreg_nxt = '0;
                        w_short     = !w_last && (r_bit_cnt != '0);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_data_in   <= '0;
            r_fram_pend <= 1'b0;
            r_data_fram <= 1'b0;
            r_short_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            if (w_complete) r_data_in <= w_word;
            r_fram_pend <= w_complete;
            r_data_fram <= r_fram_pend & EN;
            r_short_err <= w_short;
        end
    end

`ifdef HANMING_SPI_RX_STAT_EN
    logic [15:0] r_good_cnt, r_short_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt  <= '0;
            r_short_cnt <= '0;
        end else if (EN) begin
            if (r_data_fram && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
            if (r_short_err && (r_short_cnt != 16'hFFFF)) r_short_cnt <= r_short_cnt + 16'd1;
        end
    end

    assign good_cnt  = r_good_cnt;
    assign short_cnt = r_short_cnt;
`endif

    assign Data_in   = r_data_in;
    assign Data_Fram = r_data_fram;
    assign short_err = r_short_err;
    assign busy      = (r_state == S_SHIFT);
    assign dbg_state = r_state;
endmodule
